// File: rtl/painterengine_gpu_blend_stream.sv
// Stream pixel blender: joins foreground (src1) and destination (src2) streams,
// applies a tinted COPY/ALPHA/ADD/MULTIPLY blend through a 4-stage stallable pipeline.
//
// state | meaning
// IDLE  | waiting for start; config latched on start
// RUN   | accepting joined pixels until the job count is reached
// DRAIN | inputs closed, waiting for the last output handshake
module painterengine_gpu_blend_stream #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                       i_wire_clock,
  input  logic                       i_wire_resetn,
  input  logic                       i_wire_start,
  input  logic [COUNT_WIDTH-1:0]     i_wire_pixel_count,
  input  logic [1:0]                 i_wire_mode,
  input  logic                       i_wire_argb_mode,
  input  logic [4*CHANNEL_WIDTH-1:0] i_wire_blend,
  input  logic [4*CHANNEL_WIDTH-1:0] i_wire_src1_data,
  input  logic                       i_wire_src1_valid,
  output logic                       o_wire_src1_ready,
  input  logic [4*CHANNEL_WIDTH-1:0] i_wire_src2_data,
  input  logic                       i_wire_src2_valid,
  output logic                       o_wire_src2_ready,
  output logic [4*CHANNEL_WIDTH-1:0] o_wire_data,
  output logic                       o_wire_valid,
  input  logic                       i_wire_ready,
  output logic                       o_wire_busy,
  output logic                       o_wire_done
);

  localparam int W  = CHANNEL_WIDTH;
  localparam int PW = 4 * CHANNEL_WIDTH;
  localparam int IW = 2 * CHANNEL_WIDTH + 2;

  typedef logic [W-1:0] chan_t;
  typedef chan_t [3:0] quad_t;  // [0]=A [1]=R [2]=G [3]=B

  localparam chan_t                  CMAX    = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  localparam logic [1:0] MODE_COPY  = 2'd0;
  localparam logic [1:0] MODE_ALPHA = 2'd1;
  localparam logic [1:0] MODE_ADD   = 2'd2;
  localparam logic [1:0] MODE_MUL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Rounded x*y/M without a divider: bias by half an LSB, then fold the high part back in.
  function automatic chan_t mul_norm(input chan_t x, input chan_t y);
    logic [IW-1:0] t;
    logic [IW-1:0] s;
    t = IW'(x) * IW'(y) + (IW'(1) << (W - 1));
    s = (t + (t >> W)) >> W;
    return s[W-1:0];
  endfunction

  function automatic chan_t sat_add(input chan_t x, input chan_t y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[W] ? CMAX : s[W-1:0];
  endfunction

  function automatic quad_t unpack(input logic [PW-1:0] pix, input logic argb);
    quad_t q;
    for (int i = 0; i < 4; i++) begin
      q[i] = argb ? pix[(3-i)*W +: W] : pix[i*W +: W];
    end
    return q;
  endfunction

  function automatic logic [PW-1:0] pack(input quad_t q, input logic argb);
    logic [PW-1:0] pix;
    pix = '0;
    for (int i = 0; i < 4; i++) begin
      if (argb) pix[(3-i)*W +: W] = q[i];
      else      pix[i*W +: W]     = q[i];
    end
    return pix;
  endfunction

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
  logic [COUNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic [1:0]               mode_q;
  logic                     argb_q;
  quad_t                    blend_q;
  logic                     done_q, done_d;
  logic                     cfg_load;

  logic                     v0_q, v1_q, v2_q, v3_q;
  quad_t                    c1_q, c2_q;
  quad_t                    t1_q, c2b_q;
  quad_t                    x_q, y_q;
  logic [PW-1:0]            data_q;

  logic                     en;
  logic                     run;
  logic                     accept;
  logic                     out_hs;
  quad_t                    t1_d;
  quad_t                    x_d, y_d;
  quad_t                    res_d;
  chan_t                    ea;
  chan_t                    inv_ea;

  assign en     = !v3_q || i_wire_ready;
  assign run    = (state_q == ST_RUN);
  assign accept = run && en && i_wire_src1_valid && i_wire_src2_valid;
  assign out_hs = v3_q && i_wire_ready;

  assign o_wire_src1_ready = run && en && i_wire_src2_valid;
  assign o_wire_src2_ready = run && en && i_wire_src1_valid;
  assign o_wire_data       = data_q;
  assign o_wire_valid      = v3_q;
  assign o_wire_busy       = (state_q != ST_IDLE);
  assign o_wire_done       = done_q;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    cfg_load  = 1'b0;
    if (out_hs) out_cnt_d = out_cnt_q + CNT_ONE;
    unique case (state_q)
      ST_IDLE: begin
        if (i_wire_start) begin
          cfg_load  = 1'b1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (i_wire_pixel_count == '0) done_d  = 1'b1;
          else                          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
          if (in_cnt_q + CNT_ONE == count_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_hs && (out_cnt_q + CNT_ONE == count_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    t1_d = '0;
    for (int i = 0; i < 4; i++) begin
      t1_d[i] = mul_norm(c1_q[i], blend_q[i]);
    end
  end

  // Every mode reduces to sat(x + y) in the last stage; y is zero where no sum is needed.
  always_comb begin
    ea     = t1_q[0];
    inv_ea = CMAX - ea;
    x_d    = t1_q;
    y_d    = '0;
    unique case (mode_q)
      MODE_COPY: begin
        y_d = '0;
      end
      MODE_ALPHA: begin
        for (int i = 1; i < 4; i++) begin
          x_d[i] = mul_norm(t1_q[i], ea);
        end
        for (int i = 0; i < 4; i++) begin
          y_d[i] = mul_norm(c2b_q[i], inv_ea);
        end
      end
      MODE_ADD: begin
        y_d = c2b_q;
      end
      MODE_MUL: begin
        for (int i = 0; i < 4; i++) begin
          x_d[i] = mul_norm(t1_q[i], c2b_q[i]);
        end
      end
      default: y_d = '0;
    endcase
  end

  always_comb begin
    res_d = '0;
    for (int i = 0; i < 4; i++) begin
      res_d[i] = sat_add(x_q[i], y_q[i]);
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      count_q   <= '0;
      mode_q    <= MODE_COPY;
      argb_q    <= 1'b0;
      blend_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      if (cfg_load) begin
        count_q <= i_wire_pixel_count;
        mode_q  <= i_wire_mode;
        argb_q  <= i_wire_argb_mode;
        blend_q <= unpack(i_wire_blend, 1'b1);
      end
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      c1_q   <= '0;
      c2_q   <= '0;
      t1_q   <= '0;
      c2b_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      data_q <= '0;
    end else if (en) begin
      v0_q <= accept;
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (accept) begin
        c1_q <= unpack(i_wire_src1_data, argb_q);
        c2_q <= unpack(i_wire_src2_data, argb_q);
      end
      if (v0_q) begin
        t1_q  <= t1_d;
        c2b_q <= c2_q;
      end
      if (v1_q) begin
        x_q <= x_d;
        y_q <= y_d;
      end
      if (v2_q) data_q <= pack(res_d, argb_q);
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_blend_stream.sv
// Directed bench for painterengine_gpu_blend_stream: scoreboard fed by an
// independent rounding-division model, checked with immediate assertions.
module tb_painterengine_gpu_blend_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pcount;
  logic [1:0]  mode;
  logic        argb;
  logic [31:0] blend;
  logic [31:0] s1_data, s2_data;
  logic        s1v, s2v, s1r, s2r;
  logic [31:0] o_data;
  logic        o_valid, rdy, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int last_out_cyc = 0;
  logic [31:0] last_out_data = '0;
  logic [31:0] exp_q[$];

  logic [1:0]  cfg_mode;
  logic        cfg_argb;
  logic [31:0] cfg_blend;

  logic        stall_prev = 1'b0;
  logic [31:0] prev_data  = '0;

  painterengine_gpu_blend_stream dut (
    .i_wire_clock       (clk),
    .i_wire_resetn      (rst_n),
    .i_wire_start       (start),
    .i_wire_pixel_count (pcount),
    .i_wire_mode        (mode),
    .i_wire_argb_mode   (argb),
    .i_wire_blend       (blend),
    .i_wire_src1_data   (s1_data),
    .i_wire_src1_valid  (s1v),
    .o_wire_src1_ready  (s1r),
    .i_wire_src2_data   (s2_data),
    .i_wire_src2_valid  (s2v),
    .o_wire_src2_ready  (s2r),
    .o_wire_data        (o_data),
    .o_wire_valid       (o_valid),
    .i_wire_ready       (rdy),
    .o_wire_busy        (busy),
    .o_wire_done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mn(input int x, input int y);
    return (2 * x * y + 255) / 510;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] p1, input logic [31:0] p2,
                                        input logic [1:0] md, input logic ab,
                                        input logic [31:0] bl);
    int a1[4], a2[4], bb[4], t[4], r[4];
    int ea;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a1[i] = ab ? 32'(p1[(3-i)*8 +: 8]) : 32'(p1[i*8 +: 8]);
      a2[i] = ab ? 32'(p2[(3-i)*8 +: 8]) : 32'(p2[i*8 +: 8]);
      bb[i] = 32'(bl[(3-i)*8 +: 8]);
      t[i]  = mn(a1[i], bb[i]);
    end
    ea = t[0];
    for (int i = 0; i < 4; i++) begin
      case (md)
        2'd0:    r[i] = t[i];
        2'd1:    r[i] = (i == 0) ? sat(ea + mn(a2[0], 255 - ea))
                                 : sat(mn(t[i], ea) + mn(a2[i], 255 - ea));
        2'd2:    r[i] = sat(t[i] + a2[i]);
        default: r[i] = mn(t[i], a2[i]);
      endcase
    end
    res = '0;
    for (int i = 0; i < 4; i++) begin
      if (ab) res[(3-i)*8 +: 8] = r[i][7:0];
      else    res[i*8 +: 8]     = r[i][7:0];
    end
    return res;
  endfunction

  // Scoreboard monitor: push on input join, pop on output handshake, watch stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s1v && s2v && s1r && s2r) begin
        exp_q.push_back(model(s1_data, s2_data, cfg_mode, cfg_argb, cfg_blend));
        acc_cyc = cyc;
      end
      if (o_valid && rdy) begin
        if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 32'd1);
        else chk("out_data", o_data, exp_q.pop_front());
        last_out_cyc  = cyc;
        last_out_data = o_data;
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", o_data, prev_data);
      end
      stall_prev = o_valid && !rdy;
      prev_data  = o_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic start_job(input logic [31:0] cnt, input logic [1:0] md, input logic ab,
                           input logic [31:0] bl);
    pcount = cnt; mode = md; argb = ab; blend = bl; start = 1'b1;
    cfg_mode = md; cfg_argb = ab; cfg_blend = bl;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_pixel(input logic [31:0] d1, input logic [31:0] d2, input logic rnd);
    logic got;
    got = 1'b0;
    s1_data = d1; s2_data = d2; s1v = 1'b1;
    s2v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = s1v && s2v && s1r && s2r;
      @(posedge clk); #1;
      if (!got && rnd) s2v = 1'($urandom_range(0, 1));
    end
    chk("accept_seen", 32'(got), 32'd1);
  endtask

  task automatic idle_inputs();
    s1v = 1'b0; s2v = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({tag, "_done_lat"}, cyc - last_out_cyc, 32'd1);
        chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic        ab;
    logic [31:0] bl;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] ex;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    logic [31:0] rb;
    vecs[0] = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFF0000FF, 32'hFFFF0000};
    vecs[1] = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'h80FF0000, 32'hFF0000FF, 32'hFF80007F};
    vecs[2] = '{2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000FF80, 32'hFF0000FF, 32'h7F0080FF};
    vecs[3] = '{2'd2, 1'b1, 32'hFFFFFFFF, 32'hFFC00010, 32'h8060F0F0, 32'hFFFFF0FF};
    vecs[4] = '{2'd3, 1'b1, 32'hFFFFFFFF, 32'hFF808080, 32'hFF80FF00, 32'hFF408000};
    vecs[5] = '{2'd0, 1'b1, 32'h80FF80FF, 32'hFFFFFFFF, 32'h12345678, 32'h80FF80FF};

    rst_n = 1'b0; start = 1'b0; pcount = '0; mode = '0; argb = 1'b1; blend = '0;
    s1_data = '0; s2_data = '0; s1v = 1'b0; s2v = 1'b0; rdy = 1'b1;
    cfg_mode = '0; cfg_argb = 1'b1; cfg_blend = '0;
    #12;
    chk("rst_data", o_data, 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready1", 32'(s1r), 32'd0);
    chk("rst_ready2", 32'(s2r), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-pixel spec vectors with latency and done timing.
    for (int v = 0; v < 6; v++) begin
      start_job(32'd1, vecs[v].md, vecs[v].ab, vecs[v].bl);
      chk("busy_run", 32'(busy), 32'd1);
      push_pixel(vecs[v].p1, vecs[v].p2, 1'b0);
      idle_inputs();
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (o_valid) seen = 1'b1;
      end
      chk($sformatf("latency_v%0d", v), cyc - acc_cyc, 32'd4);
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_data", v), last_out_data, vecs[v].ex);
    end

    // Eight pixels, random src2 bubbles, 5-cycle downstream stall after the first output.
    rdy = 1'b0;
    start_job(32'd8, 2'd1, 1'b0, 32'hC0FF80E0);
    fork
      begin
        for (int p = 0; p < 8; p++) push_pixel($urandom, $urandom, 1'b1);
        @(negedge clk);
        chk("ready1_after_last", 32'(s1r), 32'd0);
        chk("ready2_after_last", 32'(s2r), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
      end
      begin
        logic fv;
        fv = 1'b0;
        for (int k = 0; k < 300 && !fv; k++) begin
          @(negedge clk);
          if (o_valid) fv = 1'b1;
        end
        chk("first_out_seen", 32'(fv), 32'd1);
        repeat (5) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    wait_done("burst8");

    // Zero-length job.
    start_job(32'd0, 2'd2, 1'b1, 32'hFFFFFFFF);
    chk("cnt0_done", 32'(done), 32'd1);
    chk("cnt0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("cnt0_done_clear", 32'(done), 32'd0);
    chk("cnt0_busy_after", 32'(busy), 32'd0);

    // Start with new mode/count during RUN is ignored.
    start_job(32'd4, 2'd2, 1'b1, 32'hFFC0A080);
    push_pixel($urandom, $urandom, 1'b0);
    start = 1'b1; mode = 2'd3; pcount = 32'd1;
    push_pixel($urandom, $urandom, 1'b0);
    start = 1'b0;
    push_pixel($urandom, $urandom, 1'b0);
    chk("mid_start_busy", 32'(busy), 32'd1);
    push_pixel($urandom, $urandom, 1'b0);
    idle_inputs();
    wait_done("ignore_start");

    // Reset with three pixels in flight, then a fresh two-pixel job.
    rdy = 1'b0;
    start_job(32'd5, 2'd3, 1'b1, 32'hFFFFFFFF);
    for (int p = 0; p < 3; p++) push_pixel($urandom, $urandom, 1'b0);
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_data", o_data, 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_ready1", 32'(s1r), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    start_job(32'd2, 2'd1, 1'b1, 32'hA0FFFF80);
    push_pixel($urandom, $urandom, 1'b0);
    push_pixel($urandom, $urandom, 1'b0);
    idle_inputs();
    wait_done("post_reset");

    // New start coinciding with the last output handshake is ignored.
    rdy = 1'b0;
    start_job(32'd1, 2'd0, 1'b1, 32'hFFFFFFFF);
    rb = $urandom;
    push_pixel(rb, 32'h0, 1'b0);
    idle_inputs();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    chk("late_out_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rdy = 1'b1; start = 1'b1; pcount = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("late_start_done", 32'(done), 32'd1);
    chk("late_start_busy", 32'(busy), 32'd0);
    chk("late_start_data", last_out_data, rb);
    @(posedge clk); #1;
    chk("late_start_busy2", 32'(busy), 32'd0);
    chk("final_sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_blend_stream.md
Name: painterengine_gpu_blend_stream

Overview:
Parametrised, stream-based successor to the GPU pixel blender. It joins two pixel streams (src1 = foreground, src2 = destination) through valid/ready handshakes and applies one of four blend modes with a per-job ARGB tint. Output is a 4-stage pipeline with full backpressure. Jobs are framed by a pixel count, and a done pulse is issued after the last output. It sits between the src1/dst read DMAs and the write-back DMA of the GPU.

Parameters:
CHANNEL_WIDTH, 8, bits per colour/alpha channel (W); pixel = 4*W bits
COUNT_WIDTH, 32, width of the pixel counters

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  reset, asynchronous, active-low
i_wire_start  in  1  start pulse; sampled only in IDLE
i_wire_pixel_count  in  COUNT_WIDTH  pixels in the job; latched on start
i_wire_mode  in  2  0 COPY, 1 ALPHA, 2 ADD, 3 MULTIPLY; latched on start
i_wire_argb_mode  in  1  1: A at [4W-1:3W], then R,G,B. 0: A at [W-1:0], R [2W-1:W], G [3W-1:2W], B [4W-1:3W]. Latched on start
i_wire_blend  in  4W  tint, always ARGB order (ba,br,bg,bb); latched on start
i_wire_src1_data  in  4W  foreground pixel
i_wire_src1_valid  in  1  src1 valid
o_wire_src1_ready  out  1  src1 ready
i_wire_src2_data  in  4W  destination pixel
i_wire_src2_valid  in  1  src2 valid
o_wire_src2_ready  out  1  src2 ready
o_wire_data  out  4W  blended pixel, same channel order as inputs
o_wire_valid  out  1  output valid
i_wire_ready  in  1  downstream ready
o_wire_busy  out  1  high in RUN/DRAIN
o_wire_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (async): FSM=IDLE, counters 0, all pipeline valids 0. Outputs: o_wire_data=0, o_wire_valid=0, both readies=0, busy=0, done=0. Reset mid-job discards all in-flight pixels.
- M = 2^W-1. Define mul_norm(x,y): t = x*y + 2^(W-1); result = (t + (t>>W)) >> W. This is exact rounded x*y/M. sat() clamps to M. Intermediates are 2W+2 bits wide.
- Per pixel, with (a1,c1) from src1, (a2,c2) from src2, and c = r/g/b:
  - ea = mul_norm(a1,ba); t1c = mul_norm(c1,bc).
  - COPY: a = ea, c = t1c.
  - ALPHA: c = sat(mul_norm(t1c,ea) + mul_norm(c2,M-ea)); a = sat(ea + mul_norm(a2,M-ea)).
  - ADD: c = sat(t1c + c2); a = sat(ea + a2).
  - MULTIPLY: c = mul_norm(t1c,c2); a = mul_norm(ea,a2).
- Pipeline and stall:
  - 4 register stages: S0 unpack/latch, S1 ea/t1c, S2 products, S3 sum/saturate/pack.
  - Global advance en = !o_wire_valid || i_wire_ready.
  - When en=0, every stage holds; o_wire_data must stay stable while o_wire_valid=1 and i_wire_ready=0.
  - Latency: accept at cycle N gives o_wire_valid at N+4 when there is no stall.
  - Throughput: 1 pixel/cycle.
- Input join:
  - o_wire_src1_ready = RUN & en & i_wire_src2_valid; o_wire_src2_ready = RUN & en & i_wire_src1_valid.
  - A pixel is accepted only when both valids are high in the same cycle. Src1 and src2 never decouple.
  - Bubbles (one valid only) insert an invalid slot; ordering is preserved.
- Counters:
  - in_cnt increments on each accept; out_cnt increments on each o_wire_valid & i_wire_ready.
  - Both clear on start.
- FSM:
  - IDLE: on start, latch config. If count=0, pulse done the next cycle and stay IDLE; otherwise go to RUN.
  - RUN: accept pixels; when in_cnt reaches count, go to DRAIN. Readies deassert in the same cycle as the last accept's registered update.
  - DRAIN: readies 0. When out_cnt reaches count, go to IDLE; done is high for 1 cycle coincident with the IDLE entry.
  - busy = RUN|DRAIN.
- start outside IDLE is ignored. Config changes mid-job have no effect.
- The last output handshake and a new start in the same cycle: start is ignored (FSM still DRAIN).

Test Plan:
1. W=8, argb_mode=1, ALPHA, blend=0xFFFFFFFF, count=1, src1=0xFFFF0000, src2=0xFF0000FF -> o_wire_data=0xFFFF0000 exactly 4 cycles after accept; done 1 cycle after the output handshake, busy falls with it.
2. ALPHA, src1=0x80FF0000, src2=0xFF0000FF -> 0xFF80007F. Same case with argb_mode=0 and byte-reversed inputs (src1=0x0000FF80, src2=0xFF0000FF) -> 0x7F0080FF.
3. ADD, src1=0xFFC00010, src2=0x8060F0F0 -> 0xFFFFF0FF (saturation on A, R, B). MULTIPLY, src1=0xFF808080, src2=0xFF80FF00 -> 0xFF408000. COPY, blend=0x80FF80FF, src1=0xFFFFFFFF -> 0x80FF80FF.
4. count=8, src2_valid toggled randomly, i_wire_ready held low for 5 cycles after the first output -> o_wire_data stable during the stall, 8 outputs in input order, no drops or duplicates, readies=0 after the 8th accept, done after the 8th output.
5. count=0 start -> done pulse next cycle, busy never rises. start pulsed during RUN with a different mode -> ignored, results use the original mode.
6. Assert reset mid-job with 3 pixels in flight -> next cycle all outputs 0, FSM IDLE. A fresh count=2 job then completes normally with correct data.
